modrm_fetch: RTL and testbench
==============================

MODRM_FETCH -- requirements
Module: modrm_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, physical address width (16..24).
REQ-002 Parameter WB_EN, default 1, enables memory writeback states (0 = writeback requests complete without bus writes).
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 hold  in  1  stall; when 1 no state, register or output changes.
REQ-006 start  in  1  begin decode; sampled only in IDLE.
REQ-007 size, dir  in  1,1  0=8/1=16-bit; 0=rm,r / 1=r,rm; sampled with start.
REQ-008 ip_in  in  ADDR_W  address of ModRM byte; sampled with start.
REQ-009 base  in  ADDR_W  data segment base added to every data offset.
REQ-010 regs  in  128  ax,cx,dx,bx,sp,bp,si,di, 16 bits each, ax at [15:0].
REQ-011 address  out  ADDR_W  byte bus address; in  in  8  read data, valid same cycle as address.
REQ-012 out  out  8  write data; we  out  1  write strobe.
REQ-013 op1, op2  out  16  dst/src operands; modrm  out  8; ea  out  16  offset; ip_out  out  ADDR_W  address after last fetched byte.
REQ-014 op_valid  out  1  operands stable (EXEC); mem  out  1  rm operand is memory (mod!=3).
REQ-015 result  in  16; result_valid  in  1; wb  in  1  write result to rm if memory destination.
REQ-016 busy  out  1  not IDLE; done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-017 States: IDLE, MODRM, DISP8, DISP16L, DISP16H, OPL, OPH, EXEC, WBL, WBH.
REQ-018 address = ip-phase ? ip : (base + ea + byte offset) mod 2^ADDR_W; ip increments once per fetched byte.
REQ-019 IDLE: start -> MODRM, load ip from ip_in, latch size/dir.
REQ-020 MODRM: latch byte; op1 from (dir ? reg : rm), op2 from (dir ? rm : reg) register fields; size=0 maps 0-3 to al,cl,dl,bl, 4-7 to ah,ch,dh,bh.
REQ-021 ea base: rm 0..7 = bx+si, bx+di, bp+si, bp+di, si, di, (mod=0 ? 0 : bp), bx; all ea arithmetic modulo 2^16.
REQ-022 Next: mod=3 -> EXEC; mod=0,rm=6 -> DISP16L; mod=0 other -> OPL; mod=1 -> DISP8; mod=2 -> DISP16L.
REQ-023 DISP8 adds sign-extended byte -> OPL; DISP16L adds low, DISP16H adds high<<8 -> OPL.
REQ-024 OPL loads low byte into memory-side operand (op2 if dir else op1), zero upper; size=1 -> OPH else EXEC.
REQ-025 OPH reads offset (ea+1) mod 2^16 into upper byte -> EXEC; ea output never altered by OPH.
REQ-026 EXEC: op_valid=1; waits for result_valid; if wb & mem & !dir & WB_EN -> WBL, else -> IDLE with done.
REQ-027 WBL: we=1, out=result[7:0] at ea; size=1 -> WBH else IDLE with done; WBH: we=1, out=result[15:8] at ea+1 mod 2^16 -> IDLE with done.
REQ-028 Latency from start: register form 2 cycles to EXEC; each extra byte (disp/operand) adds 1.
REQ-029 start while busy ignored; result_valid outside EXEC ignored.
REQ-030 we only asserted in WBL/WBH, never two cycles for one byte.

Reset
REQ-031 reset_n=0 (overrides hold): state IDLE, ip=0, we=0, out=0, done=0, op_valid=0, op1=op2=0, ea=0, modrm=0, size=dir=0.
REQ-032 Reset mid-writeback aborts immediately; we=0 the next cycle, no further bytes written.

Structure
REQ-033 Shared package: state encoding, register index constants (AX..DI), mod constants.
REQ-034 One sub-module, modrm_ea, combinational ea base and register operand select from modrm and regs.

Verification
REQ-035 modrm=D8, size=1, dir=0, ax=1111, bx=2222 -> op1=1111, op2=2222, op_valid 2 cycles after start, no data-address cycles.
REQ-036 modrm=06, disp 34 12, base=0, mem[1234]=CD, mem[1235]=AB, size=1, dir=1 -> ea=1234, op2=ABCD, ip_out=ip_in+3.
REQ-037 modrm=46, disp FE, bp=1000, size=0 -> ea=0FFE, 8-bit operand zero-extended.
REQ-038 modrm=07, bx=FFFF, base=10000 (ADDR_W=20), size=1 -> reads at 1FFFF then 10000.
REQ-039 dir=0 memory dst, result=5AA5, wb=1 -> writes A5 at ea, 5A at ea+1, done pulse; hold=1 for 3 cycles mid-sequence freezes all outputs.
REQ-040 reset_n=0 during WBL -> no WBH write, IDLE, all outputs at reset values.

Source files
------------

// File: rtl/modrm_fetch_pkg.sv
// Shared definitions for the ModRM operand fetch unit: FSM states,
// register-file indices, ModRM "mod" field values and small helpers.
package modrm_fetch_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_MODRM,
      S_DISP8,
      S_DISP16L,
      S_DISP16H,
      S_OPL,
      S_OPH,
      S_EXEC,
      S_WBL,
      S_WBH
   } state_t;

   // Register indices in the packed regs bus (ax at [15:0])
   localparam logic [2:0] AX = 3'd0;
   localparam logic [2:0] CX = 3'd1;
   localparam logic [2:0] DX = 3'd2;
   localparam logic [2:0] BX = 3'd3;
   localparam logic [2:0] SP = 3'd4;
   localparam logic [2:0] BP = 3'd5;
   localparam logic [2:0] SI = 3'd6;
   localparam logic [2:0] DI = 3'd7;

   // ModRM mod field values
   localparam logic [1:0] MOD_NODISP = 2'd0;
   localparam logic [1:0] MOD_DISP8  = 2'd1;
   localparam logic [1:0] MOD_DISP16 = 2'd2;
   localparam logic [1:0] MOD_REG    = 2'd3;

   // rm value that means "direct 16-bit address" when mod is 0
   localparam logic [2:0] RM_DIRECT = 3'd6;

   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/modrm_fetch_if.sv
// Byte-wide memory bus between the fetch unit (master) and memory (slave).
// Read data on "in" is expected in the same cycle as "address".
interface modrm_fetch_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] address;
   logic [7:0]        in;
   logic [7:0]        out;
   logic              we;

   modport master (output address, output out, output we, input in);
   modport slave  (input address, input out, input we, output in);
endinterface

// File: rtl/modrm_ea.sv
// Combinational ModRM decode helpers: effective-address base from the rm
// field, and register operand selection (8- or 16-bit) for op1/op2.
module modrm_ea
   import modrm_fetch_pkg::*;
(
   input  logic [7:0]   modrm,
   input  logic [127:0] regs,
   input  logic         size,
   input  logic         dir,
   output logic [15:0]  ea_base,
   output logic [15:0]  op1_sel,
   output logic [15:0]  op2_sel
);

   logic [15:0] r  [8];
   logic [7:0]  r8 [8];
   logic [15:0] reg_val;
   logic [15:0] rm_val;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_split
         assign r[gi] = regs[gi*16 +: 16];
      end
   endgenerate

   // 8-bit register view: indices 0-3 are the low bytes, 4-7 the high bytes
   assign r8[AX] = r[AX][7:0];
   assign r8[CX] = r[CX][7:0];
   assign r8[DX] = r[DX][7:0];
   assign r8[BX] = r[BX][7:0];
   assign r8[SP] = r[AX][15:8];
   assign r8[BP] = r[CX][15:8];
   assign r8[SI] = r[DX][15:8];
   assign r8[DI] = r[BX][15:8];

   // Effective-address base per rm; mod=0,rm=6 starts from zero (direct)
   always_comb begin
      ea_base = 16'h0000;
      case (modrm[2:0])
         3'd0:    ea_base = r[BX] + r[SI];
         3'd1:    ea_base = r[BX] + r[DI];
         3'd2:    ea_base = r[BP] + r[SI];
         3'd3:    ea_base = r[BP] + r[DI];
         3'd4:    ea_base = r[SI];
         3'd5:    ea_base = r[DI];
         3'd6:    ea_base = (modrm[7:6] == MOD_NODISP) ? 16'h0000 : r[BP];
         default: ea_base = r[BX];
      endcase
   end

   // Register operands, zero-extended for byte size, routed by direction
   always_comb begin
      reg_val = size ? r[modrm[5:3]] : {8'h00, r8[modrm[5:3]]};
      rm_val  = size ? r[modrm[2:0]] : {8'h00, r8[modrm[2:0]]};
      op1_sel = dir ? reg_val : rm_val;
      op2_sel = dir ? rm_val  : reg_val;
   end

endmodule

// File: rtl/modrm_fetch.sv
// ModRM operand fetch: reads the ModRM byte and any displacement, fetches
// a memory operand, presents op1/op2 for execution and optionally writes
// the result back to the memory destination.
module modrm_fetch
   import modrm_fetch_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter bit WB_EN  = 1'b1
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              hold,
   input  logic              start,
   input  logic              size,
   input  logic              dir,
   input  logic [ADDR_W-1:0] ip_in,
   input  logic [ADDR_W-1:0] base,
   input  logic [127:0]      regs,
   modrm_fetch_if.master     bus,
   output logic [15:0]       op1,
   output logic [15:0]       op2,
   output logic [7:0]        modrm,
   output logic [15:0]       ea,
   output logic [ADDR_W-1:0] ip_out,
   output logic              op_valid,
   output logic              mem,
   input  logic [15:0]       result,
   input  logic              result_valid,
   input  logic              wb,
   output logic              busy,
   output logic              done
);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] ip_reg, ip_next;
   logic [7:0]        modrm_reg, modrm_next;
   logic [15:0]       ea_reg, ea_next;
   logic [15:0]       op1_reg, op1_next;
   logic [15:0]       op2_reg, op2_next;
   logic [15:0]       result_reg, result_next;
   logic              size_reg, size_next;
   logic              dir_reg, dir_next;
   logic              done_reg, done_next;

   logic [15:0]       ea_base, op1_sel, op2_sel;
   logic [15:0]       ea_off;
   logic              hi_byte, data_phase;

   // Decode uses the byte currently on the bus, which is the ModRM byte
   // during the MODRM state
   modrm_ea u_ea (
      .modrm   (bus.in),
      .regs    (regs),
      .size    (size_reg),
      .dir     (dir_reg),
      .ea_base (ea_base),
      .op1_sel (op1_sel),
      .op2_sel (op2_sel)
   );

   // Bus drive: instruction stream address, or base + ea (+1 for high byte)
   always_comb begin
      hi_byte     = (state_reg == S_OPH) || (state_reg == S_WBH);
      data_phase  = (state_reg == S_OPL) || (state_reg == S_OPH) ||
                    (state_reg == S_WBL) || (state_reg == S_WBH);
      ea_off      = ea_reg + {15'd0, hi_byte};
      bus.address = data_phase ? (base + ADDR_W'(ea_off)) : ip_reg;
      bus.we      = (state_reg == S_WBL) || (state_reg == S_WBH);
      bus.out     = (state_reg == S_WBL) ? result_reg[7:0] :
                    (state_reg == S_WBH) ? result_reg[15:8] : 8'h00;
   end

   // Next-state and datapath updates; everything holds its value by default
   always_comb begin
      state_next  = state_reg;
      ip_next     = ip_reg;
      modrm_next  = modrm_reg;
      ea_next     = ea_reg;
      op1_next    = op1_reg;
      op2_next    = op2_reg;
      result_next = result_reg;
      size_next   = size_reg;
      dir_next    = dir_reg;
      done_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_MODRM;
               ip_next    = ip_in;
               size_next  = size;
               dir_next   = dir;
            end
         end
         S_MODRM: begin
            modrm_next = bus.in;
            ip_next    = ip_reg + 1'b1;
            ea_next    = ea_base;
            op1_next   = op1_sel;
            op2_next   = op2_sel;
            case (bus.in[7:6])
               MOD_REG:    state_next = S_EXEC;
               MOD_NODISP: state_next = (bus.in[2:0] == RM_DIRECT) ? S_DISP16L : S_OPL;
               MOD_DISP8:  state_next = S_DISP8;
               default:    state_next = S_DISP16L;
            endcase
         end
         S_DISP8: begin
            ea_next    = ea_reg + sext8(bus.in);
            ip_next    = ip_reg + 1'b1;
            state_next = S_OPL;
         end
         S_DISP16L: begin
            ea_next    = ea_reg + {8'h00, bus.in};
            ip_next    = ip_reg + 1'b1;
            state_next = S_DISP16H;
         end
         S_DISP16H: begin
            ea_next    = ea_reg + {bus.in, 8'h00};
            ip_next    = ip_reg + 1'b1;
            state_next = S_OPL;
         end
         S_OPL: begin
            if (dir_reg) op2_next = {8'h00, bus.in};
            else         op1_next = {8'h00, bus.in};
            state_next = size_reg ? S_OPH : S_EXEC;
         end
         S_OPH: begin
            if (dir_reg) op2_next = {bus.in, op2_reg[7:0]};
            else         op1_next = {bus.in, op1_reg[7:0]};
            state_next = S_EXEC;
         end
         S_EXEC: begin
            if (result_valid) begin
               result_next = result;
               if (wb && mem && !dir_reg && WB_EN) begin
                  state_next = S_WBL;
               end else begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         S_WBL: begin
            if (size_reg) begin
               state_next = S_WBH;
            end else begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         S_WBH: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register; reset wins over hold
   always_ff @(posedge clock) begin
      if (!reset_n)   state_reg <= S_IDLE;
      else if (!hold) state_reg <= state_next;
   end

   // Datapath registers; reset wins over hold
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ip_reg     <= '0;
         modrm_reg  <= 8'h00;
         ea_reg     <= 16'h0000;
         op1_reg    <= 16'h0000;
         op2_reg    <= 16'h0000;
         result_reg <= 16'h0000;
         size_reg   <= 1'b0;
         dir_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else if (!hold) begin
         ip_reg     <= ip_next;
         modrm_reg  <= modrm_next;
         ea_reg     <= ea_next;
         op1_reg    <= op1_next;
         op2_reg    <= op2_next;
         result_reg <= result_next;
         size_reg   <= size_next;
         dir_reg    <= dir_next;
         done_reg   <= done_next;
      end
   end

   assign op1      = op1_reg;
   assign op2      = op2_reg;
   assign modrm    = modrm_reg;
   assign ea       = ea_reg;
   assign ip_out   = ip_reg;
   assign op_valid = (state_reg == S_EXEC);
   assign mem      = (modrm_reg[7:6] != MOD_REG);
   assign busy     = (state_reg != S_IDLE);
   assign done     = done_reg;

endmodule

// File: tb/tb_modrm_fetch.sv
// Directed bench for modrm_fetch: a table of decode vectors plus hand-written
// sequences for address wrap, writeback with hold, and reset mid-writeback.
module tb_modrm_fetch;

   localparam int AW = 20;

   logic          clock;
   logic          reset_n, hold, start, size, dir;
   logic [AW-1:0] ip_in, base;
   logic [127:0]  regs;
   logic [15:0]   op1, op2, ea, result;
   logic [7:0]    modrm;
   logic [AW-1:0] ip_out;
   logic          op_valid, mem, result_valid, wb, busy, done;

   logic [7:0]    mem_arr [0:(1<<AW)-1];
   logic [27:0]   wlog [$];

   int n_cmp  = 0;
   int n_miss = 0;

   modrm_fetch_if #(.ADDR_W(AW)) bus ();

   assign bus.in = mem_arr[bus.address];

   modrm_fetch #(.ADDR_W(AW), .WB_EN(1'b1)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .hold         (hold),
      .start        (start),
      .size         (size),
      .dir          (dir),
      .ip_in        (ip_in),
      .base         (base),
      .regs         (regs),
      .bus          (bus),
      .op1          (op1),
      .op2          (op2),
      .modrm        (modrm),
      .ea           (ea),
      .ip_out       (ip_out),
      .op_valid     (op_valid),
      .mem          (mem),
      .result       (result),
      .result_valid (result_valid),
      .wb           (wb),
      .busy         (busy),
      .done         (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory write log: one entry per clock edge that commits a byte
   always @(posedge clock) begin
      if (bus.we === 1'b1 && hold === 1'b0) wlog.push_back({bus.address, bus.out});
   end

   typedef struct {
      logic [7:0]  modrm;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        sz;
      logic        dr;
      int          lat;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] ea;
      logic        chk_ea;
      logic [19:0] ip_out;
      logic        mem;
   } vec_t;

   vec_t vt [7];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int k);
      int cyc;
      mem_arr[20'h00100] = vt[k].modrm;
      mem_arr[20'h00101] = vt[k].d0;
      mem_arr[20'h00102] = vt[k].d1;
      size  = vt[k].sz;
      dir   = vt[k].dr;
      ip_in = 20'h00100;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      while (op_valid !== 1'b1 && cyc < 12) begin
         step();
         cyc++;
      end
      chk("latency", cyc, vt[k].lat);
      chk("op1", op1, vt[k].op1);
      chk("op2", op2, vt[k].op2);
      if (vt[k].chk_ea) chk("ea", ea, vt[k].ea);
      chk("ip_out", ip_out, vt[k].ip_out);
      chk("mem", mem, vt[k].mem);
      $display("vec %0d modrm=%02h size=%0d dir=%0d lat=%0d op1=%04h op2=%04h ea=%04h ip_out=%05h",
               k, vt[k].modrm, vt[k].sz, vt[k].dr, cyc, op1, op2, ea, ip_out);
      result       = 16'hFFFF;
      result_valid = 1'b1;
      wb           = 1'b0;
      step();
      result_valid = 1'b0;
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      step();
      chk("done_pulse", done, 0);
   endtask

   // Start a 16-bit dir=0 [bx] decode and advance to EXEC
   task automatic go_exec_bx();
      mem_arr[20'h00100] = 8'h07;
      size  = 1'b1;
      dir   = 1'b0;
      ip_in = 20'h00100;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("wb_op_valid", op_valid, 1);
      chk("wb_op1", op1, 16'h1234);
   endtask

   initial begin
      int n0;
      reset_n = 1'b0; hold = 1'b1; start = 1'b0; size = 1'b0; dir = 1'b0;
      ip_in = '0; base = '0; result = 16'h0000; result_valid = 1'b0; wb = 1'b0;
      //        di       si       bp       sp       bx       dx       cx       ax
      regs = {16'h0020, 16'h0010, 16'h1000, 16'h5555, 16'h2222, 16'h4404, 16'h3303, 16'h1111};

      mem_arr[20'h01234] = 8'hCD; mem_arr[20'h01235] = 8'hAB;
      mem_arr[20'h00FFE] = 8'h9C;
      mem_arr[20'h02232] = 8'h78; mem_arr[20'h02233] = 8'h56;
      mem_arr[20'h00020] = 8'h5E;
      mem_arr[20'h0FFFF] = 8'h22; mem_arr[20'h00000] = 8'h11;
      mem_arr[20'h1FFFF] = 8'hEF; mem_arr[20'h10000] = 8'hBE;
      mem_arr[20'h02222] = 8'h34; mem_arr[20'h02223] = 8'h12;

      //          modrm  d0     d1     sz    dr    lat op1       op2       ea        chk   ip_out     mem
      vt[0] = '{8'hD8, 8'h00, 8'h00, 1'b1, 1'b0, 2, 16'h1111, 16'h2222, 16'h0000, 1'b0, 20'h00101, 1'b0};
      vt[1] = '{8'h06, 8'h34, 8'h12, 1'b1, 1'b1, 6, 16'h1111, 16'hABCD, 16'h1234, 1'b1, 20'h00103, 1'b1};
      vt[2] = '{8'h46, 8'hFE, 8'h00, 1'b0, 1'b0, 4, 16'h009C, 16'h0011, 16'h0FFE, 1'b1, 20'h00102, 1'b1};
      vt[3] = '{8'hEE, 8'h00, 8'h00, 1'b0, 1'b1, 2, 16'h0033, 16'h0044, 16'h0000, 1'b0, 20'h00101, 1'b0};
      vt[4] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4, 16'h5678, 16'h1111, 16'h2232, 1'b1, 20'h00101, 1'b1};
      vt[5] = '{8'h93, 8'h00, 8'hF0, 1'b0, 1'b1, 5, 16'h0004, 16'h005E, 16'h0020, 1'b1, 20'h00103, 1'b1};
      vt[6] = '{8'h0E, 8'hFF, 8'hFF, 1'b1, 1'b0, 6, 16'h1122, 16'h3303, 16'hFFFF, 1'b1, 20'h00103, 1'b1};

      // Reset asserted together with hold: reset must still take effect
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_done", done, 0);
      chk("rst_ip", ip_out, 0);
      chk("rst_ea", ea, 0);
      chk("rst_modrm", modrm, 0);
      chk("rst_op1", op1, 0);
      chk("rst_op2", op2, 0);
      reset_n = 1'b1;
      hold    = 1'b0;
      step();

      for (int k = 0; k < 7; k++) run_vec(k);

      // bx=FFFF with a 20-bit base: low byte at 1FFFF, high byte wraps to 10000
      regs[63:48] = 16'hFFFF;
      base = 20'h10000;
      mem_arr[20'h00100] = 8'h07;
      size = 1'b1; dir = 1'b0; ip_in = 20'h00100; start = 1'b1;
      step();
      start = 1'b0;
      chk("wrap_modrm_addr", bus.address, 20'h00100);
      step();
      chk("wrap_opl_addr", bus.address, 20'h1FFFF);
      step();
      chk("wrap_oph_addr", bus.address, 20'h10000);
      step();
      chk("wrap_op_valid", op_valid, 1);
      chk("wrap_op1", op1, 16'hBEEF);
      chk("wrap_ea", ea, 16'hFFFF);
      $display("wrap seq op1=%04h ea=%04h", op1, ea);
      result_valid = 1'b1; wb = 1'b0;
      step();
      result_valid = 1'b0;
      chk("wrap_done", done, 1);
      regs[63:48] = 16'h2222;
      base = 20'h00000;
      step();

      // Writeback of 5AA5 to [bx] with a 3-cycle hold inside WBL
      go_exec_bx();
      n0 = wlog.size();
      result = 16'h5AA5; result_valid = 1'b1; wb = 1'b1;
      step();
      result_valid = 1'b0; wb = 1'b0;
      chk("wbl_we", bus.we, 1);
      chk("wbl_addr", bus.address, 20'h02222);
      chk("wbl_out", bus.out, 8'hA5);
      hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         step();
         chk("hold_we", bus.we, 1);
         chk("hold_addr", bus.address, 20'h02222);
         chk("hold_out", bus.out, 8'hA5);
         chk("hold_done", done, 0);
      end
      hold = 1'b0;
      step();
      chk("wbh_we", bus.we, 1);
      chk("wbh_addr", bus.address, 20'h02223);
      chk("wbh_out", bus.out, 8'h5A);
      step();
      chk("wb_end_we", bus.we, 0);
      chk("wb_done", done, 1);
      chk("wb_busy", busy, 0);
      step();
      chk("wb_done_pulse", done, 0);
      chk("wb_count", wlog.size() - n0, 2);
      chk("wb_byte0", wlog[n0], {20'h02222, 8'hA5});
      chk("wb_byte1", wlog[n0+1], {20'h02223, 8'h5A});
      $display("writeback seq bytes=%0d", wlog.size() - n0);

      // Reset during WBL: the high byte must never be written
      go_exec_bx();
      n0 = wlog.size();
      result = 16'h5AA5; result_valid = 1'b1; wb = 1'b1;
      step();
      result_valid = 1'b0; wb = 1'b0;
      chk("rwb_we", bus.we, 1);
      reset_n = 1'b0;
      step();
      chk("rwb_we_off", bus.we, 0);
      chk("rwb_busy", busy, 0);
      chk("rwb_op_valid", op_valid, 0);
      chk("rwb_out", bus.out, 0);
      chk("rwb_done", done, 0);
      chk("rwb_op1", op1, 0);
      chk("rwb_op2", op2, 0);
      chk("rwb_ea", ea, 0);
      chk("rwb_modrm", modrm, 0);
      chk("rwb_ip", ip_out, 0);
      reset_n = 1'b1;
      step();
      step();
      chk("rwb_idle_we", bus.we, 0);
      chk("rwb_count", wlog.size() - n0, 1);
      chk("rwb_byte0", wlog[n0], {20'h02222, 8'hA5});
      $display("reset-in-writeback seq bytes=%0d", wlog.size() - n0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
